// File: rtl/serial_in_buffer_if.sv
// Serial link receive-side bundle: ser_c/ser_d in, decoded frame and status out.
// The DUT takes the slave modport; whoever drives the wire takes master.
interface serial_in_buffer_if #(
   parameter int A_WIDTH = 7,
   parameter int D_WIDTH = 8
);
   logic               ser_c;
   logic               ser_d;
   logic [A_WIDTH-1:0] addr_out;
   logic [D_WIDTH-1:0] data_out;
   logic               valid;
   logic               frame_err;
   logic               busy;
   logic [2:0]         dbg_state;

   modport master (
      output ser_c, ser_d,
      input  addr_out, data_out, valid, frame_err, busy, dbg_state
   );

   modport slave (
      input  ser_c, ser_d,
      output addr_out, data_out, valid, frame_err, busy, dbg_state
   );
endinterface

// File: rtl/serial_in_buffer.sv
// Deserialises one start/addr/sep/data/sep/stop frame from ser_c/ser_d.
// Define SERIN_SYNC_EN to add 2-flop synchronisers for an asynchronous transmitter.
module serial_in_buffer #(
   parameter int A_WIDTH = 7,
   parameter int D_WIDTH = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   serial_in_buffer_if.slave bus
);
   // Outputs: valid and frame_err are one-cycle pulses, never high together;
   // addr_out/data_out change only together with a valid pulse.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_SEP1 = 3'd2,
      S_DATA = 3'd3,
      S_SEP2 = 3'd4,
      S_STOP = 3'd5
   } state_t;

   localparam int MAXW = (A_WIDTH > D_WIDTH) ? A_WIDTH : D_WIDTH;
   localparam int CW   = $clog2(MAXW + 1);
   localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] A_LAST  = CW'(A_WIDTH - 1);
   localparam logic [CW-1:0] D_LAST  = CW'(D_WIDTH - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic               w_ser_c_in;
   logic               w_ser_d_in;
   logic               r_ser_c_r;
   logic               r_ser_c_rr;
   logic               r_ser_d_r;
   logic               w_edge;
   logic               w_bit;
   logic               w_timeout;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_bit_cnt;
   logic [TW-1:0]      r_to_cnt;
   logic [A_WIDTH-1:0] r_a_sh;
   logic [D_WIDTH-1:0] r_d_sh;
   logic [A_WIDTH-1:0] r_addr;
   logic [D_WIDTH-1:0] r_data;
   logic               r_valid;
   logic               r_frame_err;
   logic               r_busy;

   logic               w_valid_nxt;
   logic               w_ferr_nxt;
   logic               w_shift_a;
   logic               w_shift_d;

`ifdef SERIN_SYNC_EN
   logic [1:0] r_sync_c;
   logic [1:0] r_sync_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_c <= '0;
         r_sync_d <= '0;
      end else begin
         r_sync_c <= {r_sync_c[0], bus.ser_c};
         r_sync_d <= {r_sync_d[0], bus.ser_d};
      end
   end

   assign w_ser_c_in = r_sync_c[1];
   assign w_ser_d_in = r_sync_d[1];
`else
   assign w_ser_c_in = bus.ser_c;
   assign w_ser_d_in = bus.ser_d;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ser_c_r  <= 1'b0;
         r_ser_c_rr <= 1'b0;
         r_ser_d_r  <= 1'b0;
      end else begin
         r_ser_c_r  <= w_ser_c_in;
         r_ser_c_rr <= r_ser_c_r;
         r_ser_d_r  <= w_ser_d_in;
      end
   end

   assign w_edge = r_ser_c_r & ~r_ser_c_rr;
   assign w_bit  = r_ser_d_r;
   // A real edge in the same cycle beats the timeout.
   assign w_timeout = ~w_edge && (r_state != S_IDLE) && (r_to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_edge) begin
         case (r_state)
            S_IDLE:  if (!w_bit) w_state_nxt = S_ADDR;
            S_ADDR:  if (r_bit_cnt == A_LAST) w_state_nxt = S_SEP1;
            S_SEP1:  w_state_nxt = S_DATA;
            S_DATA:  if (r_bit_cnt == D_LAST) w_state_nxt = S_SEP2;
            S_SEP2:  w_state_nxt = S_STOP;
            S_STOP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_comb begin
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = w_timeout;
      w_shift_a   = 1'b0;
      w_shift_d   = 1'b0;
      if (w_edge) begin
         w_valid_nxt = (r_state == S_STOP) && !w_bit;
         w_ferr_nxt  = w_bit && ((r_state == S_IDLE) || (r_state == S_STOP));
         w_shift_a   = (r_state == S_ADDR);
         w_shift_d   = (r_state == S_DATA);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt   <= '0;
         r_to_cnt    <= '0;
         r_a_sh      <= '0;
         r_d_sh      <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid     <= w_valid_nxt;
         r_frame_err <= w_ferr_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);

         if (w_edge || (w_state_nxt == S_IDLE)) r_to_cnt <= '0;
         else                                   r_to_cnt <= r_to_cnt + 1'b1;

         // bit_cnt runs only while staying inside a field, so it enters each field at 0.
         if (w_timeout) begin
            r_bit_cnt <= '0;
         end else if (w_edge) begin
            if ((w_shift_a && w_state_nxt == S_ADDR) || (w_shift_d && w_state_nxt == S_DATA))
               r_bit_cnt <= r_bit_cnt + 1'b1;
            else
               r_bit_cnt <= '0;
         end

         if (w_timeout) begin
            r_a_sh <= '0;
            r_d_sh <= '0;
         end else begin
            if (w_shift_a) r_a_sh <= {r_a_sh[A_WIDTH-2:0], w_bit};
            if (w_shift_d) r_d_sh <= {r_d_sh[D_WIDTH-2:0], w_bit};
         end

         if (w_valid_nxt) begin
            r_addr <= r_a_sh;
            r_data <= r_d_sh;
         end
      end
   end

   assign bus.addr_out  = r_addr;
   assign bus.data_out  = r_data;
   assign bus.valid     = r_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.busy      = r_busy;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_in_buffer.sv
// Directed bench for serial_in_buffer: good frames, back-to-back, bad start/stop,
// timeout, mid-frame reset; latency expectations follow SERIN_SYNC_EN.
module tb_serial_in_buffer;
   localparam int A_WIDTH = 7;
   localparam int D_WIDTH = 8;
   localparam int TIMEOUT = 64;
`ifdef SERIN_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   cyc;
   int   n_valid;
   int   n_ferr;
   int   n_both;
   int   last_valid_cyc;
   int   last_ferr_cyc;

   serial_in_buffer_if #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) bus_if ();

   serial_in_buffer #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse monitor: counts high cycles of each pulse output.
   always @(negedge clk) begin
      if (bus_if.valid === 1'b1) begin
         n_valid++;
         last_valid_cyc = cyc;
      end
      if (bus_if.frame_err === 1'b1) begin
         n_ferr++;
         last_ferr_cyc = cyc;
      end
      if (bus_if.valid === 1'b1 && bus_if.frame_err === 1'b1) n_both++;
   end

   task automatic send_bit(input logic b, output int rise_cyc);
      @(negedge clk);
      bus_if.ser_d = b;
      bus_if.ser_c = 1'b1;
      rise_cyc = cyc;
      repeat (2) @(negedge clk);
      bus_if.ser_c = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [A_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d,
                             input logic stop_b, output int stop_cyc);
      int t;
      send_bit(1'b0, t);
      for (int i = A_WIDTH - 1; i >= 0; i--) send_bit(a[i], t);
      send_bit(1'($urandom_range(0, 1)), t);
      for (int i = D_WIDTH - 1; i >= 0; i--) send_bit(d[i], t);
      send_bit(1'($urandom_range(0, 1)), t);
      send_bit(stop_b, stop_cyc);
   endtask

   task automatic test_reset;
      reset_n      = 1'b0;
      bus_if.ser_c = 1'b0;
      bus_if.ser_d = 1'b0;
      #10;
      reset_n = 1'b1;
      #1;
      checks++; if (bus_if.addr_out !== 7'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus_if.data_out); end
      checks++; if (bus_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_if.valid); end
      checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus_if.frame_err); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
      checks++; if (bus_if.dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus_if.dbg_state); end
   endtask

   task automatic test_first_frame;
      int v0, f0, t, stop_c;
      v0 = n_valid; f0 = n_ferr;
      send_bit(1'b0, t);
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", bus_if.busy); end
      for (int i = A_WIDTH - 1; i >= 0; i--) send_bit(i == 6 || i == 0, t);
      send_bit(1'b1, t);
      for (int i = D_WIDTH - 1; i >= 0; i--) send_bit(i == 7 || i == 0, t);
      send_bit(1'b0, t);
      send_bit(1'b0, stop_c);
      repeat (6) @(negedge clk);
      checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL first_valid_count got %0d want 1", n_valid - v0); end
      checks++; if (bus_if.addr_out !== 7'h41) begin errors++; $display("FAIL first_addr got %h want 41", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h81) begin errors++; $display("FAIL first_data got %h want 81", bus_if.data_out); end
      checks++; if (n_ferr != f0) begin errors++; $display("FAIL first_ferr_count got %0d want %0d", n_ferr, f0); end
      checks++;
      if (last_valid_cyc - stop_c != 2 + SYNC_LAT) begin
         errors++; $display("FAIL first_latency got %0d want %0d", last_valid_cyc - stop_c, 2 + SYNC_LAT);
      end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL first_busy_end got %b want 0", bus_if.busy); end
   endtask

   task automatic test_back_to_back;
      int v0, t;
      v0 = n_valid;
      send_frame(7'h7F, 8'hFF, 1'b0, t);
      send_frame(7'h00, 8'h00, 1'b0, t);
      repeat (6) @(negedge clk);
      checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", n_valid - v0); end
      checks++; if (bus_if.addr_out !== 7'h00) begin errors++; $display("FAIL b2b_addr got %h want 00", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h00) begin errors++; $display("FAIL b2b_data got %h want 00", bus_if.data_out); end
   endtask

   task automatic test_bad_stop;
      int v0, f0, t;
      v0 = n_valid; f0 = n_ferr;
      send_frame(7'h33, 8'hCC, 1'b1, t);
      repeat (6) @(negedge clk);
      checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL stop_ferr_count got %0d want 1", n_ferr - f0); end
      checks++; if (n_valid != v0) begin errors++; $display("FAIL stop_valid_count got %0d want %0d", n_valid, v0); end
      checks++; if (bus_if.addr_out !== 7'h00) begin errors++; $display("FAIL stop_addr_hold got %h want 00", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h00) begin errors++; $display("FAIL stop_data_hold got %h want 00", bus_if.data_out); end
   endtask

   task automatic test_bad_start;
      int f0, t;
      f0 = n_ferr;
      send_bit(1'b1, t);
      repeat (4) @(negedge clk);
      checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL start_ferr_count got %0d want 1", n_ferr - f0); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL start_busy got %b want 0", bus_if.busy); end
   endtask

   task automatic test_timeout;
      int v0, f0, t, c0;
      v0 = n_valid; f0 = n_ferr;
      send_bit(1'b0, t);
      for (int i = 0; i < 5; i++) send_bit(1'b1, c0);
      for (int i = 0; i < 100 && n_ferr == f0; i++) @(negedge clk);
      checks++;
      if (n_ferr - f0 != 1) begin
         errors++; $display("FAIL timeout_ferr_count got %0d want 1", n_ferr - f0);
      end
      checks++;
      if (last_ferr_cyc - c0 != 2 + SYNC_LAT + TIMEOUT) begin
         errors++; $display("FAIL timeout_latency got %0d want %0d", last_ferr_cyc - c0, 2 + SYNC_LAT + TIMEOUT);
      end
      while (cyc < c0 + 70) @(negedge clk);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", bus_if.busy); end
      checks++; if (n_valid != v0) begin errors++; $display("FAIL timeout_valid_count got %0d want %0d", n_valid, v0); end
      checks++; if (bus_if.addr_out !== 7'h00) begin errors++; $display("FAIL timeout_addr_hold got %h want 00", bus_if.addr_out); end
      send_frame(7'h2A, 8'h55, 1'b0, t);
      repeat (6) @(negedge clk);
      checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL after_to_valid got %0d want 1", n_valid - v0); end
      checks++; if (bus_if.addr_out !== 7'h2A) begin errors++; $display("FAIL after_to_addr got %h want 2a", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h55) begin errors++; $display("FAIL after_to_data got %h want 55", bus_if.data_out); end
   endtask

   task automatic test_mid_reset;
      int v0, f0, t;
      send_bit(1'b0, t);
      for (int i = 0; i < A_WIDTH; i++) send_bit(1'b1, t);
      send_bit(1'b0, t);
      for (int i = 0; i < 3; i++) send_bit(1'b1, t);
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (bus_if.addr_out !== 7'h00) begin errors++; $display("FAIL mid_reset_addr got %h want 00", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h want 00", bus_if.data_out); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", bus_if.busy); end
      v0 = n_valid; f0 = n_ferr;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (n_valid != v0 || n_ferr != f0) begin errors++; $display("FAIL mid_reset_pulses got %0d/%0d want %0d/%0d", n_valid, n_ferr, v0, f0); end
      send_frame(7'h01, 8'h80, 1'b0, t);
      repeat (6) @(negedge clk);
      checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL post_reset_valid got %0d want 1", n_valid - v0); end
      checks++; if (bus_if.addr_out !== 7'h01) begin errors++; $display("FAIL post_reset_addr got %h want 01", bus_if.addr_out); end
      checks++; if (bus_if.data_out !== 8'h80) begin errors++; $display("FAIL post_reset_data got %h want 80", bus_if.data_out); end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      n_valid = 0; n_ferr = 0; n_both = 0;
      last_valid_cyc = 0; last_ferr_cyc = 0;
      test_reset();
      test_first_frame();
      test_back_to_back();
      test_bad_stop();
      test_bad_start();
      test_timeout();
      test_mid_reset();
      checks++; if (n_both != 0) begin errors++; $display("FAIL valid_and_ferr_overlap got %0d want 0", n_both); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
